psum_buff_ctrl: RTL and testbench

Sequencer for the partial-sum buffer (PSUM_BUFF) behind the PE array. For one output tile it zero-fills the buffer, gates PE-array result strobes into accumulate pushes for a configured number of passes, then drains the tile while re-zeroing the buffer. It captures the drained words onto a registered result stream for the write-back path.

---
 rtl/psum_buff_ctrl_pkg.sv | 15 +
 rtl/psum_buff_ctrl_slot_counter.sv | 45 ++++
 rtl/psum_buff_ctrl.sv | 167 ++++++++++++++++
 tb/tb_psum_buff_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_buff_ctrl_pkg.sv
// Shared state encoding and default buffer sizing for the partial-sum
// buffer sequencer, its counter and the PSUM_BUFF model.
package psum_pkg;
  localparam int BUF_DEPTH      = 8;
  localparam int BUF_ADDR_WIDTH = 3;
  localparam int BUF_DATA_WIDTH = 25;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4
  } psum_state_e;
endpackage

// File: rtl/psum_buff_ctrl_slot_counter.sv
// Slot/pass counter pair: the slot wraps at DEPTH-1 and the wrap advances the
// pass. Clear has priority over increment.
module psum_slot_counter #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  input  logic [PASS_WIDTH-1:0] i_passes,
  output logic                  o_slot_last,
  output logic                  o_pass_last,
  output logic                  o_wrap
);
  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] SLOT_ONE  = ADDR_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_ONE  = PASS_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_slot;
  logic [PASS_WIDTH-1:0] r_pass;

  // Slot and pass registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= {ADDR_WIDTH{1'b0}};
      r_pass <= {PASS_WIDTH{1'b0}};
    end else if (i_clr) begin
      r_slot <= {ADDR_WIDTH{1'b0}};
      r_pass <= {PASS_WIDTH{1'b0}};
    end else if (i_inc) begin
      if (o_slot_last) begin
        r_slot <= {ADDR_WIDTH{1'b0}};
        r_pass <= r_pass + PASS_ONE;
      end else begin
        r_slot <= r_slot + SLOT_ONE;
      end
    end
  end

  assign o_slot_last = (r_slot == LAST_SLOT);
  assign o_pass_last = (r_pass == (i_passes - PASS_ONE));
  assign o_wrap      = i_inc & o_slot_last;
endmodule

// File: rtl/psum_buff_ctrl.sv
// Partial-sum buffer sequencer: zero-fills the buffer, gates PE strobes into
// accumulate pushes for the configured passes, then drains while re-zeroing.
module psum_buff_ctrl
  import psum_pkg::*;
#(
  parameter int DEPTH      = BUF_DEPTH,
  parameter int ADDR_WIDTH = BUF_ADDR_WIDTH,
  parameter int PASS_WIDTH = 8,
  parameter int DATA_WIDTH = BUF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  input  logic                  pe_valid,
  output logic                  p_init,
  output logic                  p_valid_data,
  output logic                  p_write_zero,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  input  logic                  valid_fifo_out,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overrun
);
  localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);

  psum_state_e           r_state;
  logic [PASS_WIDTH-1:0] r_passes;
  logic                  r_p_init;
  logic                  r_p_write_zero;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_valid;
  logic                  r_res_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_slot_last;
  logic w_pass_last;
  logic w_wrap;
  logic w_in_accum;

  assign w_in_accum = (r_state == ACCUM);

  // Counter steering; each phase leaves the counter at zero for the next one.
  always_comb begin
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      IDLE:    w_cnt_clr = start;
      INIT: begin
        w_cnt_inc = 1'b1;
        w_cnt_clr = w_slot_last;
      end
      ACCUM: begin
        w_cnt_inc = pe_valid;
        w_cnt_clr = w_wrap & w_pass_last;
      end
      DRAIN: begin
        w_cnt_inc = 1'b1;
        w_cnt_clr = w_slot_last;
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  psum_slot_counter #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PASS_WIDTH (PASS_WIDTH)
  ) u_slot_counter (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_cnt_clr),
    .i_inc       (w_cnt_inc),
    .i_passes    (r_passes),
    .o_slot_last (w_slot_last),
    .o_pass_last (w_pass_last),
    .o_wrap      (w_wrap)
  );

  // Job sequencing, result capture and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_passes       <= {PASS_WIDTH{1'b0}};
      r_p_init       <= 1'b0;
      r_p_write_zero <= 1'b0;
      r_res_data     <= {DATA_WIDTH{1'b0}};
      r_res_valid    <= 1'b0;
      r_res_last     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      if (pe_valid && !w_in_accum) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_passes <= (cfg_passes == {PASS_WIDTH{1'b0}}) ? PASS_ONE : cfg_passes;
            r_err    <= 1'b0;
            r_p_init <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= INIT;
          end
        end
        INIT: begin
          if (w_wrap) begin
            r_p_init <= 1'b0;
            r_state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_wrap && w_pass_last) begin
            r_p_write_zero <= 1'b1;
            r_state        <= DRAIN;
          end
        end
        DRAIN: begin
          // A missing head word is dropped from the stream and flagged.
          if (valid_fifo_out) begin
            r_res_data  <= fifo_out;
            r_res_valid <= 1'b1;
            r_res_last  <= w_slot_last;
          end else begin
            r_err <= 1'b1;
          end
          if (w_wrap) begin
            r_p_write_zero <= 1'b0;
            r_state        <= FLUSH;
          end
        end
        FLUSH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_p_init       <= 1'b0;
          r_p_write_zero <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  assign p_init       = r_p_init;
  assign p_valid_data = w_in_accum & pe_valid;
  assign p_write_zero = r_p_write_zero;
  assign res_data     = r_res_data;
  assign res_valid    = r_res_valid;
  assign res_last     = r_res_last;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_overrun  = r_err;
endmodule

// File: tb/tb_psum_buff_ctrl.sv
// Bench for psum_buff_ctrl: a PSUM_BUFF queue model plus a job-level reference
// model checked every cycle, directed literal checks and randomized jobs.
`timescale 1ns/1ps
module tb_psum_buff_ctrl;
  import psum_pkg::*;
  localparam int D  = BUF_DEPTH;
  localparam int DW = BUF_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    cfg_passes = 8'd0;
  logic          pe_valid = 1'b0;
  logic          p_init, p_valid_data, p_write_zero;
  logic [DW-1:0] fifo_out = '0;
  logic          valid_fifo_out = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_valid, res_last, busy, done, err_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // PE lanes and buffer environment
  logic [DW-1:0] lane [4];
  logic [DW-1:0] buf_q [$];
  logic [DW-1:0] buf_h;
  logic          op_init = 1'b0, op_vd = 1'b0, op_wz = 1'b0;
  logic [DW-1:0] op_sum = '0;

  // Reference model (values expected in the current cycle)
  bit            m_busy, m_accum, m_flush;
  int            m_init_left, m_drain_left, m_pushes, m_idx, m_passes;
  logic [DW-1:0] m_acc [D];
  bit            e_done, e_rv, e_rl, e_err;
  logic [DW-1:0] e_rd;
  logic [DW-1:0] lsum;
  bit            cur_acc;

  // Monitor records
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] last_word;
  int  last_cyc, done_cyc, first_init, init_cnt, pvd_cnt, first_wz, wz_cnt;
  bit  done_seen;
  int  s_cyc, p_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psum_buff_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes), .pe_valid(pe_valid),
    .p_init(p_init), .p_valid_data(p_valid_data), .p_write_zero(p_write_zero),
    .fifo_out(fifo_out), .valid_fifo_out(valid_fifo_out),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
    .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic upd_head();
    valid_fifo_out = (buf_q.size() > 0);
    fifo_out = (buf_q.size() > 0) ? buf_q[0] : '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_accum = 0; m_flush = 0;
    m_init_left = 0; m_drain_left = 0; m_pushes = 0; m_idx = 0; m_passes = 1;
    e_done = 0; e_rv = 0; e_rl = 0; e_err = 0; e_rd = '0;
    for (int i = 0; i < D; i++) m_acc[i] = '0;
  endtask

  // Buffer applies the operations requested in the previous cycle just after the edge.
  initial forever begin
    @(posedge clk); #1;
    if (op_init && buf_q.size() < D) buf_q.push_back('0);
    if (op_vd) begin
      buf_h = (buf_q.size() > 0) ? buf_q.pop_front() : '0;
      buf_q.push_back(buf_h + op_sum);
    end
    if (op_wz) begin
      if (buf_q.size() > 0) buf_h = buf_q.pop_front();
      buf_q.push_back('0);
    end
    op_init = 1'b0; op_vd = 1'b0; op_wz = 1'b0;
    upd_head();
  end

  // Per-cycle compare against the model, then advance the model one cycle.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_p_init", p_init, 0);
        chk("rst_p_valid_data", p_valid_data, 0);
        chk("rst_p_write_zero", p_write_zero, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_overrun, 0);
        model_reset();
        buf_q.delete();
        op_init = 1'b0; op_vd = 1'b0; op_wz = 1'b0;
        upd_head();
      end else begin
        chk("p_init", p_init, m_init_left > 0);
        chk("p_valid_data", p_valid_data, m_accum && pe_valid);
        chk("p_write_zero", p_write_zero, m_drain_left > 0);
        chk("busy", busy, m_busy);
        chk("done", done, e_done);
        chk("res_valid", res_valid, e_rv);
        chk("res_last", res_last, e_rl);
        chk("err_overrun", err_overrun, e_err);
        if (e_rv) chk("res_data", res_data, e_rd);

        if (p_init) begin if (init_cnt == 0) first_init = cyc; init_cnt++; end
        if (p_write_zero) begin if (wz_cnt == 0) first_wz = cyc; wz_cnt++; end
        if (p_valid_data) pvd_cnt++;
        if (res_valid) begin
          got_q.push_back(res_data);
          if (res_last) begin last_word = res_data; last_cyc = cyc; end
        end
        if (done) begin done_seen = 1; done_cyc = cyc; end

        lsum = lane[0] + lane[1] + lane[2] + lane[3];
        op_init = p_init; op_vd = p_valid_data; op_wz = p_write_zero; op_sum = lsum;

        cur_acc = m_accum;
        e_done = 0; e_rv = 0; e_rl = 0;
        if (pe_valid && !cur_acc) e_err = 1;
        if (!m_busy) begin
          if (start) begin
            m_passes = (cfg_passes == 8'd0) ? 1 : int'(cfg_passes);
            e_err = 0; m_busy = 1; m_init_left = D; m_pushes = 0;
            for (int i = 0; i < D; i++) m_acc[i] = '0;
          end
        end else if (m_init_left > 0) begin
          m_init_left--;
          if (m_init_left == 0) m_accum = 1;
        end else if (m_accum) begin
          if (pe_valid) begin
            m_acc[m_pushes % D] = m_acc[m_pushes % D] + lsum;
            m_pushes++;
            if (m_pushes == D * m_passes) begin
              m_accum = 0; m_drain_left = D; m_idx = 0;
            end
          end
        end else if (m_drain_left > 0) begin
          if (valid_fifo_out) begin
            e_rv = 1; e_rd = m_acc[m_idx]; e_rl = (m_idx == D - 1);
          end else begin
            e_err = 1;
          end
          m_idx++; m_drain_left--;
          if (m_drain_left == 0) m_flush = 1;
        end else if (m_flush) begin
          m_flush = 0; e_done = 1; m_busy = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lanes(input bit fixed, input int k);
    if (fixed) begin
      lane[0] = DW'(1); lane[1] = DW'(k); lane[2] = DW'(2); lane[3] = DW'(2);
    end else begin
      for (int i = 0; i < 4; i++) lane[i] = DW'($urandom_range(0, 262143));
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); last_word = '0; last_cyc = -1; done_cyc = -1;
    first_init = -1; init_cnt = 0; pvd_cnt = 0; first_wz = -1; wz_cnt = 0; done_seen = 0;
  endtask

  // mode 0: back-to-back pushes, 1: 1,0,0,1 pattern, 2: random gaps
  task automatic run_job(input int passes, input int mode, input bit fixed, input bit poke);
    int np, pushes, gi, wc;
    logic pv;
    logic [3:0] pat;
    pat = 4'b1001;
    np = (passes == 0) ? 1 : passes;
    clear_mon();
    tick(); start = 1'b1; cfg_passes = 8'(passes); s_cyc = cyc;
    tick(); start = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (i > 0) tick();
      pe_valid = poke && (i == 2);
      if (i == 3) chk("busy_in_init", busy, 1);
    end
    pushes = 0; gi = 0;
    while (pushes < np * D) begin
      tick();
      case (mode)
        0: pv = 1'b1;
        1: pv = pat[gi % 4];
        default: pv = ($urandom_range(0, 2) != 0);
      endcase
      gi++;
      pe_valid = pv;
      if (pv) begin
        set_lanes(fixed, (pushes % D) + 1);
        pushes++;
        if (pushes == np * D) p_cyc = cyc;
      end
    end
    tick(); pe_valid = 1'b0;
    if (poke) begin
      tick(); tick(); pe_valid = 1'b1;
      tick(); pe_valid = 1'b0;
    end
    wc = 0;
    while (!done_seen && wc < 60) begin tick(); wc++; end
    chk("done_within_bound", done_seen, 1);
  endtask

  task automatic chk_words(input string name, input int base, input int step);
    chk({name, "_count"}, got_q.size(), D);
    for (int i = 0; i < D && i < got_q.size(); i++) chk({name, "_word"}, got_q[i], base + step * i);
  endtask

  task automatic reset_mid();
    clear_mon();
    tick(); start = 1'b1; cfg_passes = 8'd1;
    tick(); start = 1'b0;
    repeat (D - 1) tick();
    for (int k = 1; k <= 3; k++) begin tick(); pe_valid = 1'b1; set_lanes(1, k); end
    #1 rst = 1'b1;
    #1;
    chk("t6_async_p_valid_data", p_valid_data, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_p_init", p_init, 0);
    chk("t6_async_p_write_zero", p_write_zero, 0);
    tick(); pe_valid = 1'b0;
    tick(); rst = 1'b0;
    repeat (3) tick();
    chk("t6_no_done", done_seen, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) lane[i] = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_job(1, 0, 1, 0);
    chk("t1_init_cycles", init_cnt, D);
    chk("t1_init_first", first_init, s_cyc + 1);

    run_job(2, 0, 1, 0);
    chk_words("t2", 12, 2);
    chk("t2_last_word", last_word, 26);
    chk("t2_done_after_last", done_cyc, last_cyc + 1);

    run_job(0, 0, 1, 0);
    chk_words("t3", 6, 1);
    chk("t3_pushes", pvd_cnt, D);

    run_job(1, 1, 1, 0);
    chk("t4_pushes", pvd_cnt, D);
    chk("t4_drain_after_last_push", first_wz, p_cyc + 1);
    chk_words("t4", 6, 1);

    run_job(1, 0, 1, 1);
    chk("t5_pushes", pvd_cnt, D);
    chk("t5_err_sticky", err_overrun, 1);
    run_job(1, 0, 1, 0);
    chk("t5_err_cleared", err_overrun, 0);

    reset_mid();
    run_job(1, 0, 1, 0);
    chk_words("t6_clean", 6, 1);

    repeat (12) run_job(int'($urandom_range(0, 3)), 2, 0, bit'($urandom_range(0, 1)));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
